// File: rtl/nanorv32_host_if_pkg.sv
// rtl/nanorv32_host_if_pkg.sv - shared register map, status layout and bus FSM states for the host port
package nanorv32_host_if_pkg;

  localparam logic [31:0] HOSTIF_BASE = 32'h8000_0000;

  // Register indices are mem_addr[3:2]; byte offsets are 0x0, 0x4, 0x8, 0xC.
  localparam logic [1:0] HOSTIF_TX     = 2'd0;
  localparam logic [1:0] HOSTIF_STATUS = 2'd1;
  localparam logic [1:0] HOSTIF_EXIT   = 2'd2;
  localparam logic [1:0] HOSTIF_WDOG   = 2'd3;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_DONE_BIT  = 2;
  localparam int STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_ACK   = 2'd1,
    BUS_STALL = 2'd2
  } bus_state_e;

endpackage

// File: rtl/nanorv32_host_fifo.sv
// rtl/nanorv32_host_fifo.sv - synchronous FIFO with wrap-bit pointers for console bytes
module nanorv32_host_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  // Head is forced to zero when empty so char_data never shows stale bytes.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/nanorv32_host_if.sv
// rtl/nanorv32_host_if.sv - simulation host port: console FIFO, exit code and watchdog
module nanorv32_host_if
  import nanorv32_host_if_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter int          WDOG_WIDTH   = 24,
  parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        done,
  output logic [31:0] exit_code,
  output logic        timeout
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WDOG_WIDTH-1:0] WDOG_ONE = 1;

  bus_state_e            state_q, state_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           exit_code_q, exit_code_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [1:0]    reg_sel;
  logic          accept, is_tx_push, exit_wr, wdog_wr, expire;
  logic [31:0]   status_word;
  logic          unused_addr;

  assign reg_sel     = mem_addr[3:2];
  assign unused_addr = ^mem_addr[1:0];
  assign accept      = (state_q == BUS_IDLE) && mem_req;
  assign is_tx_push  = mem_we && (reg_sel == HOSTIF_TX) && mem_be[0];
  assign exit_wr     = accept && mem_we && (reg_sel == HOSTIF_EXIT) && !done_q;
  assign wdog_wr     = accept && mem_we && (reg_sel == HOSTIF_WDOG) && !done_q;
  assign fifo_pop    = char_valid && char_ready;

  nanorv32_host_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (mem_wdata[7:0]),
    .pop       (fifo_pop),
    .head_data (char_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status_word                             = '0;
    status_word[STATUS_FULL_BIT]            = fifo_full;
    status_word[STATUS_EMPTY_BIT]           = fifo_empty;
    status_word[STATUS_DONE_BIT]            = done_q;
    status_word[STATUS_COUNT_LSB +: CW]     = fifo_count;
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    fifo_push = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (mem_req) begin
          if (is_tx_push && fifo_full) begin
            state_d = BUS_STALL;
          end else begin
            fifo_push = is_tx_push;
            rdata_d   = '0;
            if (!mem_we) begin
              case (reg_sel)
                HOSTIF_STATUS: rdata_d = status_word;
                HOSTIF_WDOG:   rdata_d = 32'(wdog_q);
                default:       rdata_d = '0;
              endcase
            end
            state_d = BUS_ACK;
          end
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      BUS_STALL: begin
        // A pop in this cycle frees the slot the stalled byte lands in.
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          rdata_d   = '0;
          state_d   = BUS_ACK;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    wdog_d      = wdog_q;
    exit_code_d = exit_code_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    expire      = 1'b0;
    if (!done_q) begin
      if (wdog_wr) begin
        wdog_d = mem_wdata[WDOG_WIDTH-1:0];
      end else if (wdog_q != '0) begin
        wdog_d = wdog_q - WDOG_ONE;
        expire = (wdog_q == WDOG_ONE);
      end
      // An EXIT write landing on the expiry cycle takes precedence.
      if (exit_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_be[i]) exit_code_d[8*i +: 8] = mem_wdata[8*i +: 8];
        end
        done_d = 1'b1;
      end else if (expire) begin
        exit_code_d = TIMEOUT_CODE;
        timeout_d   = 1'b1;
        done_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BUS_IDLE;
      rdata_q     <= '0;
      exit_code_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      exit_code_q <= exit_code_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      wdog_q      <= wdog_d;
    end
  end

  assign mem_ready  = (state_q == BUS_ACK);
  assign mem_rdata  = rdata_q;
  assign char_valid = !fifo_empty;
  assign done       = done_q;
  assign exit_code  = exit_code_q;
  assign timeout    = timeout_q;

endmodule
